// File: rtl/dmem_lane_ctrl.sv
// Load/store controller between the MEM stage and four byte-lane data-memory banks (lane 3 = MSB).
// Optional feature macro: DMEM_ALIGN_CHECK_EN (flag misaligned half/word accesses instead of forcing alignment).
module dmem_lane_ctrl #(
  parameter int ADDR_W      = 11,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              busy,
  output logic [3:0]        lane_rd_en,
  output logic [3:0]        lane_wr_en,
  output logic [ADDR_W-3:0] lane_addr,
  output logic [31:0]       lane_wdata,
  input  logic [31:0]       lane_rdata,
  input  logic [3:0]        lane_valid
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t            state_r, next_state_s;
  logic [1:0]        off_r, size_r;
  logic              signed_r, we_r;
  logic [3:0]        mask_r, seen_r;
  logic [31:0]       cap_r;
  logic [CNT_W-1:0]  cnt_r;

  logic              accept_s, bad_s, done_s, timeout_s;
  logic [1:0]        off_s;
  logic [3:0]        mask_s, seen_next_s;
  logic [31:0]       wdata_rep_s, cap_next_s, rdata_next_s;
  logic              err_next_s;

  logic              req_ready_r, resp_valid_r, resp_err_r, busy_r;
  logic [31:0]       resp_rdata_r, lane_wdata_r;
  logic [3:0]        lane_rd_en_r, lane_wr_en_r;
  logic [ADDR_W-3:0] lane_addr_r;

  // Byte offset b lives on lane 3-b; halves occupy lanes 3:2 or 1:0.
  function automatic logic [3:0] lane_mask(input logic [1:0] off, input logic [1:0] size);
    case (size)
      2'b00:   lane_mask = 4'b1000 >> off;
      2'b01:   lane_mask = off[1] ? 4'b0011 : 4'b1100;
      2'b10:   lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] store_rep(input logic [31:0] wd, input logic [1:0] size);
    case (size)
      2'b00:   store_rep = {4{wd[7:0]}};
      2'b01:   store_rep = {2{wd[15:0]}};
      default: store_rep = wd;
    endcase
  endfunction

  function automatic logic [31:0] load_align(input logic [31:0] d, input logic [1:0] off,
                                             input logic [1:0] size, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'b00:   b = d[31:24];
      2'b01:   b = d[23:16];
      2'b10:   b = d[15:8];
      default: b = d[7:0];
    endcase
    h = off[1] ? d[15:0] : d[31:16];
    case (size)
      2'b00:   load_align = {{24{sgn & b[7]}}, b};
      2'b01:   load_align = {{16{sgn & h[15]}}, h};
      default: load_align = d;
    endcase
  endfunction

  // Request decode: effective offset, error classification, lane mask and replicated store data
  always_comb begin
    accept_s = req_valid & req_ready_r;
`ifdef DMEM_ALIGN_CHECK_EN
    off_s = req_addr[1:0];
    case (req_size)
      2'b01:   bad_s = req_addr[0];
      2'b10:   bad_s = |req_addr[1:0];
      2'b11:   bad_s = 1'b1;
      default: bad_s = 1'b0;
    endcase
`else
    bad_s = (req_size == 2'b11);
    case (req_size)
      2'b01:   off_s = {req_addr[1], 1'b0};
      2'b10:   off_s = 2'b00;
      default: off_s = req_addr[1:0];
    endcase
`endif
    mask_s      = lane_mask(off_s, req_size);
    wdata_rep_s = store_rep(req_wdata, req_size);
  end

  // Lane collection: accumulate valid pulses on masked lanes and their read bytes
  always_comb begin
    seen_next_s = seen_r | (lane_valid & mask_r);
    cap_next_s  = cap_r;
    for (int k = 0; k < 4; k++) begin
      if (lane_valid[k] && mask_r[k]) begin
        cap_next_s[8*k +: 8] = lane_rdata[8*k +: 8];
      end else begin
        cap_next_s[8*k +: 8] = cap_r[8*k +: 8];
      end
    end
    done_s    = (seen_next_s == mask_r);
    timeout_s = (cnt_r == CNT_W'(TIMEOUT_CYC - 1));
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          next_state_s = bad_s ? ST_RESP : ST_ISSUE;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_ISSUE: next_state_s = ST_WAIT;
      ST_WAIT: begin
        if (done_s || timeout_s) begin
          next_state_s = ST_RESP;
        end else begin
          next_state_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_RESP;
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Response payload: set when RESP is entered, held through backpressure, cleared on handoff
  always_comb begin
    rdata_next_s = resp_rdata_r;
    err_next_s   = resp_err_r;
    case (state_r)
      ST_IDLE: begin
        if (next_state_s == ST_RESP) begin
          rdata_next_s = 32'h0;
          err_next_s   = 1'b1;
        end else begin
          err_next_s   = resp_err_r;
        end
      end
      ST_WAIT: begin
        if (done_s) begin
          rdata_next_s = we_r ? 32'h0 : load_align(cap_next_s, off_r, size_r, signed_r);
          err_next_s   = 1'b0;
        end else if (timeout_s) begin
          rdata_next_s = 32'h0;
          err_next_s   = 1'b1;
        end else begin
          err_next_s   = resp_err_r;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          rdata_next_s = 32'h0;
          err_next_s   = 1'b0;
        end else begin
          err_next_s   = resp_err_r;
        end
      end
      default: err_next_s = resp_err_r;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= next_state_s;
  end

  // Request context captured on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      off_r    <= 2'b00;
      size_r   <= 2'b00;
      signed_r <= 1'b0;
      we_r     <= 1'b0;
      mask_r   <= 4'b0000;
    end else if (accept_s) begin
      off_r    <= off_s;
      size_r   <= req_size;
      signed_r <= req_signed;
      we_r     <= req_we;
      mask_r   <= bad_s ? 4'b0000 : mask_s;
    end
  end

  // Seen/capture registers and WAIT timeout counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_r <= 4'b0000;
      cap_r  <= 32'h0;
      cnt_r  <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_ISSUE: begin
          seen_r <= 4'b0000;
          cap_r  <= 32'h0;
          cnt_r  <= {CNT_W{1'b0}};
        end
        ST_WAIT: begin
          seen_r <= seen_next_s;
          cap_r  <= cap_next_s;
          cnt_r  <= cnt_r + CNT_W'(1);
        end
        default: begin
          seen_r <= seen_r;
        end
      endcase
    end
  end

  // Output registers; lane strobes are valid only for the single ISSUE cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready_r  <= 1'b1;
      busy_r       <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_rdata_r <= 32'h0;
      lane_rd_en_r <= 4'b0000;
      lane_wr_en_r <= 4'b0000;
      lane_addr_r  <= {(ADDR_W-2){1'b0}};
      lane_wdata_r <= 32'h0;
    end else begin
      req_ready_r  <= (next_state_s == ST_IDLE);
      busy_r       <= (next_state_s != ST_IDLE);
      resp_valid_r <= (next_state_s == ST_RESP);
      resp_err_r   <= err_next_s;
      resp_rdata_r <= rdata_next_s;
      lane_rd_en_r <= ((next_state_s == ST_ISSUE) && !req_we) ? mask_s : 4'b0000;
      lane_wr_en_r <= ((next_state_s == ST_ISSUE) && req_we) ? mask_s : 4'b0000;
      lane_addr_r  <= (next_state_s == ST_ISSUE) ? req_addr[ADDR_W-1:2] : {(ADDR_W-2){1'b0}};
      lane_wdata_r <= ((next_state_s == ST_ISSUE) && req_we) ? wdata_rep_s : 32'h0;
    end
  end

  assign req_ready  = req_ready_r;
  assign busy       = busy_r;
  assign resp_valid = resp_valid_r;
  assign resp_err   = resp_err_r;
  assign resp_rdata = resp_rdata_r;
  assign lane_rd_en = lane_rd_en_r;
  assign lane_wr_en = lane_wr_en_r;
  assign lane_addr  = lane_addr_r;
  assign lane_wdata = lane_wdata_r;

endmodule

// File: tb/tb_dmem_lane_ctrl.sv
// Bench for dmem_lane_ctrl: directed vector table, timeout/backpressure/reset sequences, and
// randomized accesses checked against a byte-addressed big-endian memory model.
module tb_dmem_lane_ctrl;

  localparam int TO = 15;

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [10:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid, resp_ready, resp_err, busy;
  logic [31:0] resp_rdata;
  logic [3:0]  lane_rd_en, lane_wr_en, lane_valid;
  logic [8:0]  lane_addr;
  logic [31:0] lane_wdata, lane_rdata;

  dmem_lane_ctrl #(.ADDR_W(11), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .busy(busy), .lane_rd_en(lane_rd_en), .lane_wr_en(lane_wr_en), .lane_addr(lane_addr),
    .lane_wdata(lane_wdata), .lane_rdata(lane_rdata), .lane_valid(lane_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [10:0] addr;
    logic [31:0] wdata;
  } op_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    logic [3:0]  rd_en;
    logic [3:0]  wr_en;
    logic [31:0] wdata;
    logic [31:0] wmask;
  } exp_t;

  typedef struct {
    op_t  op;
    exp_t ex;
  } vec_t;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] ref_mem [2048];
  logic [7:0] lane_mem [4][512];
  int         dly [4];
  logic [3:0] drop;
  logic [3:0] noise_mask;
  logic       noise_en;
  int         pend [4];
  logic [7:0] rbyte [4];
  logic [3:0] v_s;
  logic [31:0] rd_s;

  task automatic chk(input string tag, input string fld, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s.%s got=%h exp=%h", tag, fld, act, exp);
    end
  endtask

  // Lane bank emulator: one-cycle minimum latency plus per-lane extra delay, optional dropped lanes
  always @(negedge clk) begin
    rd_s = $urandom;
    v_s  = 4'b0000;
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) pend[k] = 0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (pend[k] > 0) begin
          pend[k]--;
          if (pend[k] == 0 && !drop[k]) begin
            v_s[k] = 1'b1;
            rd_s[8*k +: 8] = rbyte[k];
          end
        end
      end
      for (int k = 0; k < 4; k++) begin
        if (lane_rd_en[k] || lane_wr_en[k]) begin
          pend[k] = 1 + dly[k];
          if (lane_wr_en[k]) lane_mem[k][lane_addr] = lane_wdata[8*k +: 8];
          rbyte[k] = lane_mem[k][lane_addr];
        end
      end
      if (noise_en) v_s = v_s | (4'($urandom) & noise_mask & ~v_s);
    end
    lane_valid = v_s;
    lane_rdata = rd_s;
  end

  // Reference model: byte-addressed big-endian memory
  function automatic exp_t model(input op_t o);
    exp_t        e;
    logic        ill, mis, bad;
    logic [10:0] a, ad;
    logic [31:0] val;
    logic [3:0]  m;
    int          n, md, ln;
    ill = (o.size == 2'd3);
    mis = (o.size == 2'd1 && o.addr[0]) || (o.size == 2'd2 && o.addr[1:0] != 2'd0);
    a = o.addr;
`ifdef DMEM_ALIGN_CHECK_EN
    bad = ill || mis;
`else
    bad = ill;
    if (o.size == 2'd1) a[0] = 1'b0;
    else if (o.size == 2'd2) a[1:0] = 2'd0;
`endif
    n = 1 << o.size;
    val = 32'h0; m = 4'h0; md = 0;
    e.wdata = 32'h0; e.wmask = 32'h0;
    if (!bad) begin
      for (int i = 0; i < n; i++) begin
        ad = a + 11'(i);
        ln = 3 - int'(ad[1:0]);
        m[ln] = 1'b1;
        if (dly[ln] > md) md = dly[ln];
        if (o.we) begin
          ref_mem[ad] = o.wdata[8*(n-1-i) +: 8];
          e.wdata[8*ln +: 8] = o.wdata[8*(n-1-i) +: 8];
          e.wmask[8*ln +: 8] = 8'hFF;
        end else begin
          val = {val[23:0], ref_mem[ad]};
        end
      end
    end
    if (o.sgn && n == 1 && val[7])  val[31:8]  = 24'hFFFFFF;
    if (o.sgn && n == 2 && val[15]) val[31:16] = 16'hFFFF;
    e.err   = bad;
    e.lat   = bad ? 1 : 3 + md;
    e.rd_en = o.we ? 4'h0 : m;
    e.wr_en = o.we ? m : 4'h0;
    e.rdata = (bad || o.we) ? 32'h0 : val;
    return e;
  endfunction

  task automatic chk_reset(input string tag);
    chk(tag, "req_ready", 32'(req_ready), 32'h1);
    chk(tag, "resp_valid", 32'(resp_valid), 32'h0);
    chk(tag, "resp_err", 32'(resp_err), 32'h0);
    chk(tag, "resp_rdata", resp_rdata, 32'h0);
    chk(tag, "busy", 32'(busy), 32'h0);
    chk(tag, "lane_rd_en", 32'(lane_rd_en), 32'h0);
    chk(tag, "lane_wr_en", 32'(lane_wr_en), 32'h0);
    chk(tag, "lane_addr", 32'(lane_addr), 32'h0);
    chk(tag, "lane_wdata", lane_wdata, 32'h0);
  endtask

  // One complete access; called #1 after a rising edge
  task automatic do_op(input string tag, input op_t o, input exp_t e, input int hold);
    int lat, k;
    noise_mask = noise_en ? ~(e.rd_en | e.wr_en) : 4'h0;
    req_we = o.we; req_size = o.size; req_signed = o.sgn; req_addr = o.addr; req_wdata = o.wdata;
    req_valid = 1'b1;
    k = 0;
    while (!req_ready && k < 20) begin
      @(posedge clk); #1; k++;
    end
    chk(tag, "req_ready_idle", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_wdata = $urandom;
    lat = 1;
    chk(tag, "rd_en", 32'(lane_rd_en), 32'(e.rd_en));
    chk(tag, "wr_en", 32'(lane_wr_en), 32'(e.wr_en));
    chk(tag, "lane_addr", 32'(lane_addr), ((e.rd_en | e.wr_en) != 4'h0) ? 32'(o.addr[10:2]) : 32'h0);
    chk(tag, "lane_wdata", lane_wdata & e.wmask, e.wdata);
    chk(tag, "busy_issue", 32'(busy), 32'h1);
    while (!resp_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    chk(tag, "latency", 32'(lat), 32'(e.lat));
    for (int h = 0; h <= hold; h++) begin
      chk(tag, "resp_valid", 32'(resp_valid), 32'h1);
      chk(tag, "resp_rdata", resp_rdata, e.rdata);
      chk(tag, "resp_err", 32'(resp_err), 32'(e.err));
      chk(tag, "req_ready_resp", 32'(req_ready), 32'h0);
      chk(tag, "busy_resp", 32'(busy), 32'h1);
      if (h < hold) begin
        @(posedge clk); #1;
      end
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk(tag, "resp_valid_done", 32'(resp_valid), 32'h0);
    chk(tag, "idle_ready", 32'(req_ready), 32'h1);
    chk(tag, "idle_busy", 32'(busy), 32'h0);
  endtask

  vec_t vt [12];
  int   nv = 0;

  task automatic add_vec(input logic we, input logic [1:0] size, input logic sgn, input logic [10:0] addr,
                         input logic [31:0] wd, input logic [31:0] erd, input logic eerr, input int elat,
                         input logic [3:0] erden, input logic [3:0] ewren,
                         input logic [31:0] ewd, input logic [31:0] ewm);
    vt[nv].op.we = we; vt[nv].op.size = size; vt[nv].op.sgn = sgn; vt[nv].op.addr = addr;
    vt[nv].op.wdata = wd;
    vt[nv].ex.rdata = erd; vt[nv].ex.err = eerr; vt[nv].ex.lat = elat;
    vt[nv].ex.rd_en = erden; vt[nv].ex.wr_en = ewren; vt[nv].ex.wdata = ewd; vt[nv].ex.wmask = ewm;
    nv++;
  endtask

  initial begin
    op_t  o;
    exp_t e;
    exp_t unused_e;

    for (int i = 0; i < 2048; i++) ref_mem[i] = 8'h00;
    for (int k = 0; k < 4; k++) for (int i = 0; i < 512; i++) lane_mem[k][i] = 8'h00;
    dly = '{0, 0, 0, 0};
    drop = 4'h0; noise_mask = 4'h0; noise_en = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 11'h0; req_wdata = 32'h0; resp_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors from the scenario list
    add_vec(1'b1, 2'd2, 1'b0, 11'h1F8, 32'h12345678, 32'h0, 1'b0, 3, 4'h0, 4'hF, 32'h12345678, 32'hFFFFFFFF);
    add_vec(1'b0, 2'd2, 1'b0, 11'h1F8, 32'h0, 32'h12345678, 1'b0, 3, 4'hF, 4'h0, 32'h0, 32'h0);
    add_vec(1'b0, 2'd0, 1'b1, 11'h1F9, 32'h0, 32'h00000034, 1'b0, 3, 4'h4, 4'h0, 32'h0, 32'h0);
    add_vec(1'b1, 2'd0, 1'b0, 11'h1FB, 32'h0000009C, 32'h0, 1'b0, 3, 4'h0, 4'h1, 32'h0000009C, 32'h000000FF);
    add_vec(1'b0, 2'd0, 1'b1, 11'h1FB, 32'h0, 32'hFFFFFF9C, 1'b0, 3, 4'h1, 4'h0, 32'h0, 32'h0);
    add_vec(1'b0, 2'd0, 1'b0, 11'h1FB, 32'h0, 32'h0000009C, 1'b0, 3, 4'h1, 4'h0, 32'h0, 32'h0);
    add_vec(1'b1, 2'd1, 1'b0, 11'h1FA, 32'h0000BEEF, 32'h0, 1'b0, 3, 4'h0, 4'h3, 32'h0000BEEF, 32'h0000FFFF);
    add_vec(1'b0, 2'd1, 1'b0, 11'h1FA, 32'h0, 32'h0000BEEF, 1'b0, 3, 4'h3, 4'h0, 32'h0, 32'h0);
    add_vec(1'b0, 2'd1, 1'b1, 11'h1FA, 32'h0, 32'hFFFFBEEF, 1'b0, 3, 4'h3, 4'h0, 32'h0, 32'h0);
`ifdef DMEM_ALIGN_CHECK_EN
    add_vec(1'b0, 2'd2, 1'b0, 11'h1F9, 32'h0, 32'h0, 1'b1, 1, 4'h0, 4'h0, 32'h0, 32'h0);
    add_vec(1'b0, 2'd1, 1'b1, 11'h1F9, 32'h0, 32'h0, 1'b1, 1, 4'h0, 4'h0, 32'h0, 32'h0);
`else
    add_vec(1'b0, 2'd2, 1'b0, 11'h1F9, 32'h0, 32'h1234BEEF, 1'b0, 3, 4'hF, 4'h0, 32'h0, 32'h0);
    add_vec(1'b0, 2'd1, 1'b1, 11'h1F9, 32'h0, 32'h00001234, 1'b0, 3, 4'hC, 4'h0, 32'h0, 32'h0);
`endif
    add_vec(1'b0, 2'd3, 1'b0, 11'h1F8, 32'h0, 32'h0, 1'b1, 1, 4'h0, 4'h0, 32'h0, 32'h0);

    for (int i = 0; i < nv; i++) begin
      unused_e = model(vt[i].op);
      do_op($sformatf("vec%0d", i), vt[i].op, vt[i].ex, 0);
    end

    // Timeout: lane 2 never answers
    drop = 4'b0100;
    o.we = 1'b0; o.size = 2'd2; o.sgn = 1'b0; o.addr = 11'h1F8; o.wdata = 32'h0;
    e.rdata = 32'h0; e.err = 1'b1; e.lat = 2 + TO; e.rd_en = 4'hF; e.wr_en = 4'h0;
    e.wdata = 32'h0; e.wmask = 32'h0;
    do_op("timeout", o, e, 3);
    drop = 4'h0;
    repeat (3) @(posedge clk);
    #1;

    // Backpressure: response held for five cycles
    e = model(o);
    chk("bp", "model_word", e.rdata, 32'h1234BEEF);
    do_op("backpressure", o, e, 5);

    // Reset while in WAIT
    dly = '{0, 0, 0, 5};
    req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 11'h1F8; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midrst", "busy_wait", 32'(busy), 32'h1);
    chk("midrst", "no_resp_yet", 32'(resp_valid), 32'h0);
    rst_n = 1'b0;
    #1;
    chk_reset("midrst");
    @(posedge clk); #1;
    chk_reset("midrst_held");
    rst_n = 1'b1;
    dly = '{0, 0, 0, 0};
    repeat (8) @(posedge clk);
    #1;
    e = model(o);
    do_op("after_rst", o, e, 1);

    // Randomized accesses against the reference model
    noise_en = 1'b1;
    for (int i = 0; i < 80; i++) begin
      for (int k = 0; k < 4; k++) dly[k] = $urandom_range(0, 3);
      o.we    = 1'($urandom_range(0, 1));
      o.size  = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      o.sgn   = 1'($urandom_range(0, 1));
      o.addr  = ($urandom_range(0, 1) == 0) ? 11'($urandom_range(0, 2047)) : 11'h1F0 + 11'($urandom_range(0, 15));
      o.wdata = $urandom;
      e = model(o);
      do_op($sformatf("rnd%0d", i), o, e, $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
